// File: rtl/ace_ccu_snoop_resp_ctrl.sv
// Snoop-response sequencer: queues {sel, idx} per forwarded AC, merges one CR beat per selected master, returns it to idx.
// Optional: define ACE_CCU_SNOOP_TIMEOUT_EN to bound COLLECT and add timeout_o.
module ace_ccu_snoop_resp_ctrl #(
  parameter int unsigned NumInp        = 4,
  parameter int unsigned NumOup        = 4,
  parameter int unsigned CrWidth       = 5,
  parameter int unsigned FifoDepth     = 4,
  parameter int unsigned TimeoutCycles = 256,
  localparam int unsigned IdxW = (NumInp > 1) ? $clog2(NumInp) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        ctrl_valid_i,
  output logic                        ctrl_ready_o,
  input  logic [NumOup-1:0]           ctrl_sel_i,
  input  logic [IdxW-1:0]             ctrl_idx_i,
  input  logic [NumOup-1:0]           cr_valids_i,
  output logic [NumOup-1:0]           cr_readies_o,
  input  logic [NumOup*CrWidth-1:0]   cr_resps_i,
  output logic [NumInp-1:0]           cr_valids_o,
  input  logic [NumInp-1:0]           cr_readies_i,
  output logic [CrWidth-1:0]          cr_resp_o,
  output logic                        busy_o,
  output logic                        err_o
`ifdef ACE_CCU_SNOOP_TIMEOUT_EN
  ,
  output logic                        timeout_o
`endif
);

  localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntW = $clog2(FifoDepth + 1);
  localparam int unsigned TokW = NumOup + IdxW;

  typedef enum logic [1:0] {IDLE, COLLECT, RESP} state_e;

  logic [TokW-1:0]    mem_q [FifoDepth];
  logic [PtrW-1:0]    wptr_q, rptr_q;
  logic [CntW-1:0]    cnt_q;
  logic               fifo_push, fifo_pop, fifo_empty;
  logic [NumOup-1:0]  head_sel;
  logic [IdxW-1:0]    head_idx;

  state_e             state_q;
  logic [NumOup-1:0]  sel_q, mask_q, mask_d, cr_hs;
  logic [IdxW-1:0]    idx_q;
  logic [CrWidth-1:0] acc_q, acc_d, cr_resp_q;
  logic [NumInp-1:0]  cr_valids_q, idx_oh;
  logic               pd_seen_q, pd_any, err_set, err_q, resp_hs;
  int unsigned        pd_cnt;

`ifdef ACE_CCU_SNOOP_TIMEOUT_EN
  localparam logic [CrWidth-1:0] ErrBit = CrWidth'(2);
  logic [15:0] tmo_cnt_q;
  logic        timeout_q;
  assign timeout_o = timeout_q;
`endif

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (32'(p) == FifoDepth - 1) ? '0 : p + PtrW'(1);
  endfunction

  // Ready depends only on the registered count, so a pop never frees a slot in the same cycle.
  assign ctrl_ready_o = (cnt_q != CntW'(FifoDepth));
  assign fifo_empty   = (cnt_q == '0);
  assign fifo_push    = ctrl_valid_i & ctrl_ready_o;
  assign resp_hs      = |(cr_valids_q & cr_readies_i);
  assign fifo_pop     = !fifo_empty && ((state_q == IDLE) || (state_q == RESP && resp_hs));
  assign {head_sel, head_idx} = mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (fifo_push) mem_q[wptr_q] <= {ctrl_sel_i, ctrl_idx_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (fifo_push) wptr_q <= ptr_inc(wptr_q);
      if (fifo_pop)  rptr_q <= ptr_inc(rptr_q);
      if (fifo_push && !fifo_pop)      cnt_q <= cnt_q + CntW'(1);
      else if (!fifo_push && fifo_pop) cnt_q <= cnt_q - CntW'(1);
    end
  end

  always_comb begin
    cr_readies_o = '0;
    if (state_q == COLLECT) cr_readies_o = sel_q & ~mask_q;
    cr_hs  = cr_valids_i & cr_readies_o;
    mask_d = mask_q | cr_hs;
    acc_d  = acc_q;
    pd_cnt = 0;
    for (int j = 0; j < NumOup; j++) begin
      if (cr_hs[j]) begin
        acc_d = acc_d | cr_resps_i[j*CrWidth +: CrWidth];
        if (cr_resps_i[j*CrWidth + 2]) pd_cnt = pd_cnt + 1;
      end
    end
    pd_any  = (pd_cnt != 0);
    err_set = (pd_cnt > 1) || (pd_seen_q && pd_any);
  end

  always_comb begin
    idx_oh = '0;
    for (int i = 0; i < NumInp; i++) idx_oh[i] = (32'(idx_q) == i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      idx_q       <= '0;
      mask_q      <= '0;
      acc_q       <= '0;
      pd_seen_q   <= 1'b0;
      err_q       <= 1'b0;
      cr_valids_q <= '0;
      cr_resp_q   <= '0;
`ifdef ACE_CCU_SNOOP_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      if (err_set) err_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (fifo_pop) begin
            sel_q     <= head_sel;
            idx_q     <= head_idx;
            mask_q    <= '0;
            acc_q     <= '0;
            pd_seen_q <= 1'b0;
`ifdef ACE_CCU_SNOOP_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
            state_q   <= COLLECT;
          end
        end
        COLLECT: begin
          mask_q    <= mask_d;
          acc_q     <= acc_d;
          pd_seen_q <= pd_seen_q | pd_any;
`ifdef ACE_CCU_SNOOP_TIMEOUT_EN
          tmo_cnt_q <= tmo_cnt_q + 16'd1;
`endif
          if (mask_d == sel_q) begin
            state_q     <= RESP;
            cr_valids_q <= idx_oh;
            cr_resp_q   <= acc_d;
          end
`ifdef ACE_CCU_SNOOP_TIMEOUT_EN
          else if (tmo_cnt_q == 16'(TimeoutCycles - 1)) begin
            state_q     <= RESP;
            cr_valids_q <= idx_oh;
            cr_resp_q   <= acc_d | ErrBit;
            timeout_q   <= 1'b1;
          end
`endif
        end
        RESP: begin
          if (resp_hs) begin
            cr_valids_q <= '0;
            cr_resp_q   <= '0;
            if (fifo_pop) begin
              sel_q     <= head_sel;
              idx_q     <= head_idx;
              mask_q    <= '0;
              acc_q     <= '0;
              pd_seen_q <= 1'b0;
`ifdef ACE_CCU_SNOOP_TIMEOUT_EN
              tmo_cnt_q <= '0;
`endif
              state_q   <= COLLECT;
            end else begin
              state_q   <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cr_valids_o = cr_valids_q;
  assign cr_resp_o   = cr_resp_q;
  assign busy_o      = (state_q != IDLE) || !fifo_empty;
  assign err_o       = err_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!rst_i && state_q == RESP) begin
      assert (32'(idx_q) < NumInp && TimeoutCycles > 0);
    end
  end
`endif

endmodule
